uart_rx_1: RTL and testbench
============================

UART_RX_1 -- requirements
Module: uart_rx_1

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 1, clock cycles per serial bit (legal values ≥1).
REQ-002 SHALL provide parameter PARITY_ODD, default 0, parity mode: 0 = even parity, 1 = odd parity.
REQ-003 SHALL have port clk_1  input  1  sole clock; all logic samples on its rising edge.
REQ-004 SHALL have port rst_n_1  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port rx_1  input  1  serial line (idle high), driven by the uart_1 transmitter's tx_1.
REQ-006 SHALL have port dout_1  output  8  last received data byte.
REQ-007 SHALL have port valid_1  output  1  one-cycle pulse marking a completed frame.
REQ-008 SHALL have port parity_err_1  output  1  qualifies valid_1; received parity bit was wrong.
REQ-009 SHALL have port frame_err_1  output  1  one-cycle pulse; stop bit sampled low.
REQ-010 SHALL have port busy_1  output  1  high whenever state is not IDLE.

Function
REQ-011 SHALL use frame format: start(0), 8 data bits MSB first, parity bit, stop(1).
REQ-012 SHALL implement states IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-013 IDLE: on rx_1 = 0, SHALL move to START.
  - CLKS_PER_BIT = 1: the detecting sample is the start bit; move directly to DATA.
REQ-014 START (CLKS_PER_BIT > 1): SHALL re-sample rx_1 CLKS_PER_BIT/2 (integer) cycles after detection.
  - rx_1 = 1: false start, return to IDLE, no output pulses.
  - rx_1 = 0: move to DATA.
REQ-015 SHALL take every later sample CLKS_PER_BIT cycles after the previous one, using a bit timer of width $clog2(CLKS_PER_BIT+1).
REQ-016 DATA: SHALL shift samples in MSB first (shreg <= {shreg[6:0], rx_1}), counting 8 bits with a 3-bit counter, then move to PARITY.
REQ-017 PARITY: SHALL compute expected bit = (^shreg) XOR PARITY_ODD, store the mismatch flag, and move to STOP.
REQ-018 STOP with rx_1 = 1: on the same edge SHALL load dout_1 = shreg, pulse valid_1, drive parity_err_1 = stored mismatch, and return to IDLE.
REQ-019 STOP with rx_1 = 0: SHALL pulse frame_err_1, keep valid_1 low, leave dout_1 unchanged, and move to BREAK.
REQ-020 BREAK: SHALL wait for rx_1 = 1, then return to IDLE; a low line SHALL never be taken as a new start.
REQ-021 Latency (CLKS_PER_BIT = 1, macro off): start sampled at edge k → valid_1 high after edge k+10, for exactly one cycle.
REQ-022 parity_err_1 SHALL be low whenever valid_1 is low.
REQ-023 Back-to-back frames: a start bit sampled on the first edge after IDLE is re-entered SHALL be accepted, so one idle cycle between frames is sufficient.
REQ-024 SHALL be fully registered; no output depends combinationally on rx_1.

Reset
REQ-025 With rst_n_1 = 0 at an edge, the block SHALL go to IDLE with:
  - dout_1 = 0x00, valid_1, parity_err_1, frame_err_1, busy_1 = 0
  - counters and shift register cleared
REQ-026 Reset mid-frame SHALL discard the partial byte with no pulse; reception restarts at the next falling edge after release.

Configuration
REQ-027 SHALL support macro UART_RX_SYNC_EN.
  - Defined: rx_1 passes through a two-flop synchronizer (reset value 1) before the FSM; every latency grows by 2 cycles (REQ-021 becomes k+12, k = edge rx_1 first seen low).
  - Undefined: rx_1 feeds the FSM directly.

Structure
REQ-028 Shared package uart_pkg SHALL hold the state enum, frame constants (DATA_BITS = 8, START_LVL = 0, STOP_LVL = 1), and the parity-mode constant shared with uart_1.
REQ-029 The synchronizer SHALL be sub-module uart_sync_1, instantiated only under UART_RX_SYNC_EN.

Verification
REQ-030 uart_1 tx_1 → rx_1, CLKS_PER_BIT = 1, send 0xA5 (parity 0) → dout_1 = 0xA5, valid_1 one cycle, parity_err_1 = 0.
REQ-031 Send 0x01 and 0xFF back-to-back, one idle cycle between frames → two valid_1 pulses, dout_1 = 0x01 then 0xFF.
REQ-032 Drive 0x3C with parity bit forced to 1 → valid_1 = 1, parity_err_1 = 1, dout_1 = 0x3C.
REQ-033 Drive frame with stop = 0, rx_1 held low 5 more cycles → frame_err_1 one pulse, no valid_1, busy_1 high until rx_1 rises.
REQ-034 CLKS_PER_BIT = 16: 3-cycle low glitch → no pulses; then a full 0x5A frame → dout_1 = 0x5A.
REQ-035 Assert rst_n_1 after 4 data bits of 0xC3 → all outputs 0, no pulse; next 0x81 frame received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame constants,
// parity-mode constants shared with the uart_1 transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } uart_state_t;

    localparam int   DATA_BITS = 8;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

    // Parity mode selector values (PARITY_ODD parameter of uart_1 / uart_rx_1)
    localparam int PAR_MODE_EVEN = 0;
    localparam int PAR_MODE_ODD  = 1;

    // Parity bit the transmitter appends for a given byte and mode
    function automatic logic parity_of(input logic [7:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/uart_sync_1.sv
// Two-flop synchronizer for the serial line; resets to the idle (high) level.
module uart_sync_1 (
    input  logic clk_1,
    input  logic rst_n_1,
    input  logic d_1,
    output logic q_1
);

    logic meta;

    // Double-register the asynchronous line
    always_ff @(posedge clk_1) begin
        if (!rst_n_1) begin
            meta <= 1'b1;
            q_1  <= 1'b1;
        end else begin
            meta <= d_1;
            q_1  <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_1.sv
// UART receiver: start, 8 data bits MSB first, parity, stop.
// Optional input synchronizer enabled by defining UART_RX_SYNC_EN
// (adds 2 cycles to every latency).
module uart_rx_1 #(
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk_1,
    input  logic       rst_n_1,
    input  logic       rx_1,
    output logic [7:0] dout_1,
    output logic       valid_1,
    output logic       parity_err_1,
    output logic       frame_err_1,
    output logic       busy_1
);
    import uart_pkg::*;

    localparam int TW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
    // Half-bit delay from detection to the mid-bit start sample
    localparam logic [TW-1:0] T_HALF = (CLKS_PER_BIT > 1) ? TW'(CLKS_PER_BIT / 2 - 1) : '0;
    localparam logic PAR_ODD = (PARITY_ODD != PAR_MODE_EVEN);

    logic        rx_s;
    uart_state_t state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        par_mis;
    logic        tick;
    logic        ld_shift, ld_par, ld_out, ld_ferr;

`ifdef UART_RX_SYNC_EN
    uart_sync_1 u_sync (
        .clk_1   (clk_1),
        .rst_n_1 (rst_n_1),
        .d_1     (rx_1),
        .q_1     (rx_s)
    );
`else
    assign rx_s = rx_1;
`endif

    assign tick   = (timer_q == '0);
    assign busy_1 = (state_q != ST_IDLE);

    // State and bit-timer register
    always_ff @(posedge clk_1) begin
        if (!rst_n_1) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Next-state, bit timing and datapath strobes
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        ld_shift = 1'b0;
        ld_par   = 1'b0;
        ld_out   = 1'b0;
        ld_ferr  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_s == START_LVL) begin
                    if (CLKS_PER_BIT == 1) begin
                        // Detecting sample is already the start-bit sample
                        state_d = ST_DATA;
                        timer_d = T_FULL;
                    end else begin
                        state_d = ST_START;
                        timer_d = T_HALF;
                    end
                end
            end
            ST_START, ST_DATA, ST_PARITY, ST_STOP: begin
                if (!tick) begin
                    timer_d = timer_q - 1'b1;
                end else begin
                    timer_d = T_FULL;
                    case (state_q)
                        ST_START:  state_d = (rx_s == START_LVL) ? ST_DATA : ST_IDLE;
                        ST_DATA: begin
                            ld_shift = 1'b1;
                            if (bit_cnt == 3'(DATA_BITS - 1)) state_d = ST_PARITY;
                        end
                        ST_PARITY: begin
                            ld_par  = 1'b1;
                            state_d = ST_STOP;
                        end
                        default: begin
                            if (rx_s == STOP_LVL) begin
                                ld_out  = 1'b1;
                                state_d = ST_IDLE;
                            end else begin
                                ld_ferr = 1'b1;
                                state_d = ST_BREAK;
                            end
                        end
                    endcase
                end
            end
            ST_BREAK: begin
                // Line must return high before another start is accepted
                if (rx_s == STOP_LVL) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Shift register, parity check and registered outputs
    always_ff @(posedge clk_1) begin
        if (!rst_n_1) begin
            shreg        <= '0;
            bit_cnt      <= '0;
            par_mis      <= 1'b0;
            dout_1       <= '0;
            valid_1      <= 1'b0;
            parity_err_1 <= 1'b0;
            frame_err_1  <= 1'b0;
        end else begin
            valid_1      <= ld_out;
            parity_err_1 <= ld_out & par_mis;
            frame_err_1  <= ld_ferr;
            if (ld_shift) begin
                shreg   <= {shreg[6:0], rx_s};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (ld_par) par_mis <= (rx_s != parity_of(shreg, PAR_ODD));
            if (ld_out) dout_1 <= shreg;
        end
    end

endmodule

// File: tb/tb_uart_rx_1.sv
// Directed bench for uart_rx_1 with a scoreboard of expected frames.
// Two instances: CLKS_PER_BIT = 1 and CLKS_PER_BIT = 16.
module tb_uart_rx_1;

    typedef struct {
        logic [7:0] d;
        logic       perr;
        logic       ferr;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx1 = 1'b1, rx16 = 1'b1;
    logic [7:0] dout1, dout16;
    logic       valid1, perr1, ferr1, busy1;
    logic       valid16, perr16, ferr16, busy16;
    int         cyc = 0;
    int         tests = 0, fails = 0;
    logic       mon_en = 1'b0;
    exp_t       q1[$], q16[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_1 #(.CLKS_PER_BIT(1), .PARITY_ODD(0)) dut1 (
        .clk_1(clk), .rst_n_1(rst_n), .rx_1(rx1), .dout_1(dout1), .valid_1(valid1),
        .parity_err_1(perr1), .frame_err_1(ferr1), .busy_1(busy1));

    uart_rx_1 #(.CLKS_PER_BIT(16), .PARITY_ODD(0)) dut16 (
        .clk_1(clk), .rst_n_1(rst_n), .rx_1(rx16), .dout_1(dout16), .valid_1(valid16),
        .parity_err_1(perr16), .frame_err_1(ferr16), .busy_1(busy16));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_rx(input int which, input logic v);
        if (which == 1) rx1 = v; else rx16 = v;
    endtask

    // Drive the first nbits bits of a frame; full frames push an expectation
    task automatic send(input int which, input logic [7:0] d, input logic par,
                        input logic stp, input int nbits);
        logic [10:0] bits;
        exp_t e;
        int c;
        c = (which == 1) ? 1 : 16;
        bits = {1'b0, d, par, stp};
        e.d    = d;
        e.perr = (par != ^d);
        e.ferr = ~stp;
        e.cyc  = (cyc + 1) + c / 2 + 10 * c;
        if (nbits == 11) begin
            if (which == 1) q1.push_back(e); else q16.push_back(e);
        end
        for (int i = 0; i < nbits; i++) begin
            set_rx(which, bits[10 - i]);
            repeat (c) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        rx1 = 1'b1;
        rx16 = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard check for the CLKS_PER_BIT = 1 instance
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (valid1 || ferr1) begin
                if (q1.size() == 0) chk("dut1_unexpected_pulse", {valid1, ferr1}, 0);
                else begin
                    e = q1.pop_front();
                    chk("dut1_kind", {valid1, ferr1}, {~e.ferr, e.ferr});
                    chk("dut1_latency", cyc, e.cyc);
                    if (valid1) begin
                        chk("dut1_dout", dout1, e.d);
                        chk("dut1_perr", perr1, e.perr);
                    end
                end
            end else if (perr1) chk("dut1_perr_without_valid", perr1, 0);
        end
    end

    // Scoreboard check for the CLKS_PER_BIT = 16 instance
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (valid16 || ferr16) begin
                if (q16.size() == 0) chk("dut16_unexpected_pulse", {valid16, ferr16}, 0);
                else begin
                    e = q16.pop_front();
                    chk("dut16_kind", {valid16, ferr16}, {~e.ferr, e.ferr});
                    chk("dut16_latency", cyc, e.cyc);
                    if (valid16) begin
                        chk("dut16_dout", dout16, e.d);
                        chk("dut16_perr", perr16, e.perr);
                    end
                end
            end else if (perr16) chk("dut16_perr_without_valid", perr16, 0);
        end
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_dout1", dout1, 8'h00);
        chk("rst_flags1", {valid1, perr1, ferr1, busy1}, 4'b0000);
        chk("rst_dout16", dout16, 8'h00);
        chk("rst_flags16", {valid16, perr16, ferr16, busy16}, 4'b0000);
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        idle(2);

        // Single frame 0xA5, correct even parity
        send(1, 8'hA5, 1'b0, 1'b1, 11);
        idle(3);

        // Back-to-back 0x01 / 0xFF with one idle bit
        send(1, 8'h01, 1'b1, 1'b1, 11);
        idle(1);
        send(1, 8'hFF, 1'b0, 1'b1, 11);
        idle(3);

        // Parity forced wrong
        send(1, 8'h3C, 1'b1, 1'b1, 11);
        idle(3);

        // Stop bit low, line held low 5 more cycles
        send(1, 8'h55, 1'b0, 1'b0, 11);
        for (int i = 0; i < 5; i++) begin
            chk("break_busy_high", busy1, 1'b1);
            @(negedge clk);
        end
        chk("break_busy_still_high", busy1, 1'b1);
        rx1 = 1'b1;
        @(negedge clk);
        chk("break_busy_released", busy1, 1'b0);
        idle(3);
        send(1, 8'h96, 1'b0, 1'b1, 11);
        idle(3);

        // CLKS_PER_BIT = 16: short glitch is rejected
        rx16 = 1'b0;
        repeat (3) @(negedge clk);
        rx16 = 1'b1;
        repeat (12) @(negedge clk);
        chk("glitch_busy16", busy16, 1'b0);
        send(2, 8'h5A, 1'b0, 1'b1, 11);
        idle(20);

        // Reset after 4 data bits of 0xC3
        send(1, 8'hC3, 1'b0, 1'b1, 5);
        rst_n = 1'b0;
        rx1 = 1'b1;
        @(negedge clk);
        chk("midrst_dout1", dout1, 8'h00);
        chk("midrst_flags1", {valid1, perr1, ferr1, busy1}, 4'b0000);
        chk("midrst_dout16", dout16, 8'h00);
        rst_n = 1'b1;
        idle(3);
        chk("midrst_idle_busy", busy1, 1'b0);
        send(1, 8'h81, 1'b0, 1'b1, 11);

        // Drain: all expected frames must have arrived within the budget
        for (int i = 0; i < 200 && (q1.size() != 0 || q16.size() != 0); i++) @(negedge clk);
        idle(5);
        chk("drain_q1", q1.size(), 0);
        chk("drain_q16", q16.size(), 0);
        chk("final_dout1", dout1, 8'h81);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
